// File: rtl/secuenciador_contador_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and the
// MODO codes understood by the 4-bit up/down counter register.
package secuenciador_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CARGA  = 2'd1,
    CUENTA = 2'd2,
    FIN    = 2'd3
  } estado_t;

  // Counter mode codes; 2'b10 is never produced by the sequencer.
  localparam logic [1:0] MODO_ARRIBA = 2'b00;
  localparam logic [1:0] MODO_ABAJO  = 2'b01;
  localparam logic [1:0] MODO_CARGA  = 2'b11;

  function automatic logic [1:0] modo_cuenta(input logic dir);
    return dir ? MODO_ABAJO : MODO_ARRIBA;
  endfunction

endpackage

// File: rtl/secuenciador_contador_if.sv
// Bundle between the run requester, the sequencer and the counter register.
// The slave side is the sequencer; the master side drives requests and the counter feedback.
interface secuenciador_contador_if #(
  parameter int ANCHO   = 4,
  parameter int ANCHO_V = 4
);
  logic               START;
  logic               DIR;
  logic [ANCHO-1:0]   VALOR;
  logic [ANCHO_V-1:0] VUELTAS;
  logic               CANCEL;
  logic [ANCHO-1:0]   Q;
  logic               RCO;
  logic               ENB;
  logic [1:0]         MODO;
  logic [ANCHO-1:0]   D;
  logic               BUSY;
  logic               DONE;
  logic [ANCHO-1:0]   Q_FINAL;

  modport master (
    output START, DIR, VALOR, VUELTAS, CANCEL, Q, RCO,
    input  ENB, MODO, D, BUSY, DONE, Q_FINAL
  );

  modport slave (
    input  START, DIR, VALOR, VUELTAS, CANCEL, Q, RCO,
    output ENB, MODO, D, BUSY, DONE, Q_FINAL
  );
endinterface

// File: rtl/secuenciador_contador_vueltas.sv
// Wrap counter: cleared on run acceptance, bumped on each counted RCO.
// coincide flags that the next increment reaches the requested wrap count.
module contador_vueltas #(
  parameter int ANCHO_V = 4
) (
  input  logic               CLK,
  input  logic               RESET_L,
  input  logic               clr,
  input  logic               inc,
  input  logic [ANCHO_V-1:0] objetivo,
  output logic               coincide
);

  logic [ANCHO_V-1:0] cuenta;
  logic [ANCHO_V-1:0] siguiente;

  assign siguiente = cuenta + ANCHO_V'(1);
  assign coincide  = (siguiente == objetivo);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L)
      cuenta <= '0;
    else if (clr)
      cuenta <= '0;
    else if (inc)
      cuenta <= siguiente;
  end

endmodule

// File: rtl/secuenciador_contador.sv
// Sequencer in front of the up/down counter: load, count, wait for N wraps, stop.
// All outputs are registered from the next state so nothing is combinational from inputs.
module secuenciador_contador
  import secuenciador_pkg::*;
#(
  parameter int ANCHO   = 4,
  parameter int ANCHO_V = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_L,
  secuenciador_contador_if.slave  bus
);

  estado_t            estado;
  estado_t            nxt;
  logic               dir_q;
  logic [ANCHO_V-1:0] vueltas_q;

  logic               acepta;
  logic               clr;
  logic               inc;
  logic               cap;
  logic               coincide;

  logic               enb_n;
  logic [1:0]         modo_n;
  logic [ANCHO-1:0]   d_n;
  logic               busy_n;
  logic               done_n;

  contador_vueltas #(.ANCHO_V(ANCHO_V)) u_vueltas (
    .CLK      (CLK),
    .RESET_L  (RESET_L),
    .clr      (clr),
    .inc      (inc),
    .objetivo (vueltas_q),
    .coincide (coincide)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L)
      estado <= IDLE;
    else
      estado <= nxt;
  end

  // Run parameters are only meaningful after acceptance, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (acepta) begin
      dir_q     <= bus.DIR;
      vueltas_q <= (bus.VUELTAS == '0) ? ANCHO_V'(1) : bus.VUELTAS;
    end
  end

  always_comb begin
    nxt    = estado;
    acepta = 1'b0;
    clr    = 1'b0;
    inc    = 1'b0;
    cap    = 1'b0;
    case (estado)
      IDLE: begin
        if (bus.START) begin
          nxt    = CARGA;
          acepta = 1'b1;
          clr    = 1'b1;
        end
      end
      CARGA: nxt = bus.CANCEL ? IDLE : CUENTA;
      CUENTA: begin
        // CANCEL takes priority over a terminating RCO on the same edge.
        if (bus.CANCEL) begin
          nxt = IDLE;
        end else if (bus.RCO) begin
          inc = 1'b1;
          if (coincide) begin
            nxt = FIN;
            cap = 1'b1;
          end
        end
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // CARGA is only entered from IDLE on acceptance, so the live VALOR is the latched one.
  always_comb begin
    enb_n  = 1'b0;
    modo_n = MODO_ARRIBA;
    d_n    = '0;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (nxt)
      CARGA: begin
        enb_n  = 1'b1;
        modo_n = MODO_CARGA;
        d_n    = bus.VALOR;
        busy_n = 1'b1;
      end
      CUENTA: begin
        enb_n  = 1'b1;
        modo_n = modo_cuenta(dir_q);
        busy_n = 1'b1;
      end
      FIN: begin
        busy_n = 1'b1;
        done_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      bus.ENB     <= 1'b0;
      bus.MODO    <= MODO_ARRIBA;
      bus.D       <= '0;
      bus.BUSY    <= 1'b0;
      bus.DONE    <= 1'b0;
      bus.Q_FINAL <= '0;
    end else begin
      bus.ENB  <= enb_n;
      bus.MODO <= modo_n;
      bus.D    <= d_n;
      bus.BUSY <= busy_n;
      bus.DONE <= done_n;
      if (cap)
        bus.Q_FINAL <= bus.Q;
    end
  end

endmodule
